// File: rtl/fsm_esc_rtc.sv
// Write sequencer: streams 13 shadow-RAM entries to the RTC as one burst of strobed transfers.
// Latency: cs falls and the first select rises on the edge that samples do_it_esc in IDLE.
// Backpressure: none; a started burst always runs to completion unless reset.
module fsm_esc_rtc #(
    parameter int T_SETUP = 2,
    parameter int T_WR    = 8,
    parameter int T_HOLD  = 2,
    parameter int T_GAP   = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic do_it_esc,
    output logic a_d,
    output logic cs,
    output logic rd,
    output logic wr,
    output logic rtc_to_ram,
    output logic ram_to_rtc,
    output logic dir_ram_com_cyt,
    output logic dir_ram_dir_seg,
    output logic dir_ram_seg,
    output logic dir_ram_dir_min,
    output logic dir_ram_min,
    output logic dir_ram_dir_hora,
    output logic dir_ram_hora,
    output logic dir_ram_dir_dia,
    output logic dir_ram_dia,
    output logic dir_ram_dir_mes,
    output logic dir_ram_mes,
    output logic dir_ram_dir_anio,
    output logic dir_ram_anio,
    output logic w_ram_enable,
    output logic r_ram_enable
);

    localparam int T_MAX_A = (T_SETUP > T_WR) ? T_SETUP : T_WR;
    localparam int T_MAX_B = (T_HOLD > T_GAP) ? T_HOLD : T_GAP;
    localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int PW      = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam logic [3:0] LAST_IDX = 4'd12;

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, GAP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [12:0]   sel;
    logic          busy;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
        end
    end

    // phase_q counts clocks spent in the current state, 0 .. T_x-1
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        phase_d = phase_q + PW'(1);
        case (state_q)
            IDLE: begin
                phase_d = '0;
                if (do_it_esc) begin
                    state_d = SETUP;
                    idx_d   = '0;
                end
            end
            SETUP: if (phase_q == PW'(T_SETUP - 1)) begin
                state_d = STROBE;
                phase_d = '0;
            end
            STROBE: if (phase_q == PW'(T_WR - 1)) begin
                state_d = HOLD;
                phase_d = '0;
            end
            HOLD: if (phase_q == PW'(T_HOLD - 1)) begin
                state_d = GAP;
                phase_d = '0;
            end
            GAP: if (phase_q == PW'(T_GAP - 1)) begin
                phase_d = '0;
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    state_d = SETUP;
                    idx_d   = idx_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                phase_d = '0;
            end
        endcase
    end

    // Index 0 is the command byte (address cycle); after it, odd = address, even = data.
    always_comb begin
        busy         = (state_q == SETUP) || (state_q == STROBE) || (state_q == HOLD);
        sel          = '0;
        a_d          = 1'b1;
        cs           = 1'b1;
        wr           = 1'b1;
        rd           = 1'b1;
        rtc_to_ram   = 1'b0;
        w_ram_enable = 1'b0;
        r_ram_enable = 1'b0;
        ram_to_rtc   = 1'b0;
        if (busy) begin
            sel          = 13'd1 << idx_q;
            a_d          = (idx_q >= 4'd2) && !idx_q[0];
            cs           = 1'b0;
            wr           = (state_q != STROBE);
            r_ram_enable = 1'b1;
            ram_to_rtc   = 1'b1;
        end
    end

    assign dir_ram_com_cyt  = sel[0];
    assign dir_ram_dir_seg  = sel[1];
    assign dir_ram_seg      = sel[2];
    assign dir_ram_dir_min  = sel[3];
    assign dir_ram_min      = sel[4];
    assign dir_ram_dir_hora = sel[5];
    assign dir_ram_hora     = sel[6];
    assign dir_ram_dir_dia  = sel[7];
    assign dir_ram_dia      = sel[8];
    assign dir_ram_dir_mes  = sel[9];
    assign dir_ram_mes      = sel[10];
    assign dir_ram_dir_anio = sel[11];
    assign dir_ram_anio     = sel[12];

endmodule

// File: tb/tb_fsm_esc_rtc.sv
// Bench for fsm_esc_rtc: default-timing instance (a) and fast-timing instance (b),
// each compared every cycle against a burst-offset reference model.
module tb_fsm_esc_rtc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_a, do_a, reset_b, do_b;
    logic a_d_a, cs_a, rd_a, wr_a, r2m_a, m2r_a, wre_a, rre_a;
    logic a_d_b, cs_b, rd_b, wr_b, r2m_b, m2r_b, wre_b, rre_b;
    logic [12:0] sel_a, sel_b;

    int n_cmp = 0;
    int n_fail = 0;

    localparam logic [20:0] IDLE_V = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 13'b0};
    localparam int LA = 14;
    localparam int LB = 6;

    fsm_esc_rtc dut_a (
        .clk(clk), .reset(reset_a), .do_it_esc(do_a),
        .a_d(a_d_a), .cs(cs_a), .rd(rd_a), .wr(wr_a),
        .rtc_to_ram(r2m_a), .ram_to_rtc(m2r_a),
        .dir_ram_com_cyt(sel_a[0]), .dir_ram_dir_seg(sel_a[1]), .dir_ram_seg(sel_a[2]),
        .dir_ram_dir_min(sel_a[3]), .dir_ram_min(sel_a[4]), .dir_ram_dir_hora(sel_a[5]),
        .dir_ram_hora(sel_a[6]), .dir_ram_dir_dia(sel_a[7]), .dir_ram_dia(sel_a[8]),
        .dir_ram_dir_mes(sel_a[9]), .dir_ram_mes(sel_a[10]), .dir_ram_dir_anio(sel_a[11]),
        .dir_ram_anio(sel_a[12]),
        .w_ram_enable(wre_a), .r_ram_enable(rre_a)
    );

    fsm_esc_rtc #(.T_SETUP(1), .T_WR(3), .T_HOLD(1), .T_GAP(1)) dut_b (
        .clk(clk), .reset(reset_b), .do_it_esc(do_b),
        .a_d(a_d_b), .cs(cs_b), .rd(rd_b), .wr(wr_b),
        .rtc_to_ram(r2m_b), .ram_to_rtc(m2r_b),
        .dir_ram_com_cyt(sel_b[0]), .dir_ram_dir_seg(sel_b[1]), .dir_ram_seg(sel_b[2]),
        .dir_ram_dir_min(sel_b[3]), .dir_ram_min(sel_b[4]), .dir_ram_dir_hora(sel_b[5]),
        .dir_ram_hora(sel_b[6]), .dir_ram_dir_dia(sel_b[7]), .dir_ram_dia(sel_b[8]),
        .dir_ram_dir_mes(sel_b[9]), .dir_ram_mes(sel_b[10]), .dir_ram_dir_anio(sel_b[11]),
        .dir_ram_anio(sel_b[12]),
        .w_ram_enable(wre_b), .r_ram_enable(rre_b)
    );

    wire [20:0] out_a = {a_d_a, cs_a, rd_a, wr_a, r2m_a, m2r_a, wre_a, rre_a, sel_a};
    wire [20:0] out_b = {a_d_b, cs_b, rd_b, wr_b, r2m_b, m2r_b, wre_b, rre_b, sel_b};

    // Reference: a burst is just a clock offset c since the start edge; transfer t = c / L.
    function automatic logic [20:0] exp_vec(input bit act, input int c,
                                            input int s, input int w, input int h, input int g);
        int t, p, l;
        logic [12:0] sv;
        l  = s + w + h + g;
        sv = '0;
        if (!act) return IDLE_V;
        t = c / l;
        p = c % l;
        if (p >= s + w + h) return IDLE_V;
        sv[t] = 1'b1;
        return {(t >= 2 && t % 2 == 0), 1'b0, 1'b1, !(p >= s && p < s + w),
                1'b0, 1'b1, 1'b0, 1'b1, sv};
    endfunction

    bit act_a, act_b;
    int c_a, c_b;

    always @(posedge clk) begin
        if (!reset_a) begin
            act_a <= 1'b0; c_a <= 0;
        end else if (!act_a) begin
            if (do_a) begin act_a <= 1'b1; c_a <= 0; end
        end else if (c_a == 13 * LA - 1) begin
            act_a <= 1'b0;
        end else begin
            c_a <= c_a + 1;
        end
    end

    always @(posedge clk) begin
        if (!reset_b) begin
            act_b <= 1'b0; c_b <= 0;
        end else if (!act_b) begin
            if (do_b) begin act_b <= 1'b1; c_b <= 0; end
        end else if (c_b == 13 * LB - 1) begin
            act_b <= 1'b0;
        end else begin
            c_b <= c_b + 1;
        end
    end

    logic [20:0] exp_a, exp_b;
    always_comb exp_a = exp_vec(act_a, c_a, 2, 8, 2, 2);
    always_comb exp_b = exp_vec(act_b, c_b, 1, 3, 1, 1);

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_a = 1'b0; reset_b = 1'b0; do_a = 1'b1; do_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_cmp++;
            if (out_a !== IDLE_V) begin
                n_fail++; $display("FAIL reset_hold_a: got %h want %h", out_a, IDLE_V);
            end
            n_cmp++;
            if (out_b !== IDLE_V) begin
                n_fail++; $display("FAIL reset_hold_b: got %h want %h", out_b, IDLE_V);
            end
        end
        reset_a = 1'b1; reset_b = 1'b1;
        cyc();
        do_a = 1'b0; do_b = 1'b0;
        n_cmp++;
        if (cs_a !== 1'b0 || sel_a !== 13'h1) begin
            n_fail++; $display("FAIL release_start_a: cs=%b sel=%h want cs=0 sel=0001", cs_a, sel_a);
        end
        n_cmp++;
        if (cs_b !== 1'b0 || sel_b !== 13'h1) begin
            n_fail++; $display("FAIL release_start_b: cs=%b sel=%h want cs=0 sel=0001", cs_b, sel_b);
        end
        for (int i = 0; i < 200; i++) begin
            n_cmp++;
            if (out_a !== exp_a || out_b !== exp_b) begin
                n_fail++;
                $display("FAIL reset_drain cyc %0d: a=%h/%h b=%h/%h", i, out_a, exp_a, out_b, exp_b);
            end
            cyc();
        end
    endtask

    task automatic test_single_burst();
        int cs_lens[$], wr_lens[$], idxs[$], ads[$];
        int cs_len, wr_len, last_rise, idx;
        logic prev_cs, prev_wr;
        cs_len = 0; wr_len = 0; last_rise = 0; prev_cs = 1'b1; prev_wr = 1'b1;
        do_a = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            cyc();
            if (i == 3) do_a = 1'b0;
            n_cmp++;
            if (out_a !== exp_a) begin
                n_fail++; $display("FAIL single_model cyc %0d: got %h want %h", i, out_a, exp_a);
            end
            n_cmp++;
            if (!$onehot0(sel_a) || rre_a !== (|sel_a) || m2r_a !== (|sel_a)
                || rd_a !== 1'b1 || r2m_a !== 1'b0 || wre_a !== 1'b0) begin
                n_fail++; $display("FAIL single_monitor cyc %0d: got %h", i, out_a);
            end
            if (cs_a === 1'b0) begin
                if (prev_cs) begin
                    idx = -1;
                    for (int j = 0; j < 13; j++) if (sel_a[j]) idx = j;
                    idxs.push_back(idx);
                    ads.push_back(int'(a_d_a));
                    cs_len = 0;
                end
                cs_len++;
            end else if (!prev_cs) begin
                cs_lens.push_back(cs_len);
                last_rise = i;
            end
            if (wr_a === 1'b0) wr_len++;
            else if (!prev_wr) begin wr_lens.push_back(wr_len); wr_len = 0; end
            prev_cs = cs_a;
            prev_wr = wr_a;
        end
        n_cmp++;
        if (cs_lens.size() != 13 || wr_lens.size() != 13) begin
            n_fail++;
            $display("FAIL single_counts: cs windows %0d wr pulses %0d want 13/13", cs_lens.size(), wr_lens.size());
        end
        foreach (cs_lens[k]) begin
            n_cmp++;
            if (cs_lens[k] != 12) begin
                n_fail++; $display("FAIL cs_window %0d: got %0d want 12", k, cs_lens[k]);
            end
        end
        foreach (wr_lens[k]) begin
            n_cmp++;
            if (wr_lens[k] != 8) begin
                n_fail++; $display("FAIL wr_pulse %0d: got %0d want 8", k, wr_lens[k]);
            end
        end
        foreach (idxs[k]) begin
            n_cmp++;
            if (idxs[k] != k || ads[k] != ((k >= 2 && k % 2 == 0) ? 1 : 0)) begin
                n_fail++; $display("FAIL order %0d: sel %0d a_d %0d", k, idxs[k], ads[k]);
            end
        end
        n_cmp++;
        if (last_rise != 181) begin
            n_fail++; $display("FAIL single_end: last cs rise cyc %0d want 181", last_rise);
        end
    endtask

    task automatic test_back_to_back();
        int starts[$];
        logic prev0;
        prev0 = sel_a[0];
        do_a = 1'b1;
        for (int i = 1; i <= 400; i++) begin
            cyc();
            n_cmp++;
            if (out_a !== exp_a) begin
                n_fail++; $display("FAIL b2b_model cyc %0d: got %h want %h", i, out_a, exp_a);
            end
            if (sel_a[0] && !prev0) starts.push_back(i);
            prev0 = sel_a[0];
        end
        do_a = 1'b0;
        n_cmp++;
        if (starts.size() != 3) begin
            n_fail++; $display("FAIL b2b_count: got %0d bursts want 3", starts.size());
        end
        for (int k = 1; k < starts.size(); k++) begin
            n_cmp++;
            if (starts[k] - starts[k-1] != 183) begin
                n_fail++; $display("FAIL b2b_period %0d: got %0d want 183", k, starts[k] - starts[k-1]);
            end
        end
        for (int i = 0; i < 200; i++) begin
            cyc();
            n_cmp++;
            if (out_a !== exp_a) begin
                n_fail++; $display("FAIL b2b_drain cyc %0d: got %h want %h", i, out_a, exp_a);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        found = 1'b0;
        do_a = 1'b1;
        cyc();
        do_a = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            n_cmp++;
            if (out_a !== exp_a) begin
                n_fail++; $display("FAIL mid_model cyc %0d: got %h want %h", i, out_a, exp_a);
            end
            if (sel_a[6] === 1'b1 && wr_a === 1'b0) found = 1'b1;
            else cyc();
        end
        n_cmp++;
        if (!found) begin
            n_fail++; $display("FAIL mid_reach: strobe of index 6 not seen within 200 cycles");
        end
        reset_a = 1'b0;
        cyc();
        n_cmp++;
        if (wr_a !== 1'b1 || cs_a !== 1'b1 || sel_a !== 13'h0 || out_a !== IDLE_V) begin
            n_fail++; $display("FAIL mid_abort: got %h want %h", out_a, IDLE_V);
        end
        reset_a = 1'b1;
        for (int i = 0; i < 30; i++) begin
            cyc();
            n_cmp++;
            if (out_a !== IDLE_V) begin
                n_fail++; $display("FAIL mid_stay_idle cyc %0d: got %h want %h", i, out_a, IDLE_V);
            end
        end
    endtask

    task automatic test_fast_params();
        int cs_lens[$], wr_lens[$], idxs[$];
        int cs_len, wr_len, last_rise, idx;
        logic prev_cs, prev_wr;
        cs_len = 0; wr_len = 0; last_rise = 0; prev_cs = 1'b1; prev_wr = 1'b1;
        do_b = 1'b1;
        for (int i = 1; i <= 90; i++) begin
            cyc();
            do_b = 1'b0;
            n_cmp++;
            if (out_b !== exp_b) begin
                n_fail++; $display("FAIL fast_model cyc %0d: got %h want %h", i, out_b, exp_b);
            end
            if (cs_b === 1'b0) begin
                if (prev_cs) begin
                    idx = -1;
                    for (int j = 0; j < 13; j++) if (sel_b[j]) idx = j;
                    idxs.push_back(idx);
                    cs_len = 0;
                end
                cs_len++;
            end else if (!prev_cs) begin
                cs_lens.push_back(cs_len);
                last_rise = i;
            end
            if (wr_b === 1'b0) wr_len++;
            else if (!prev_wr) begin wr_lens.push_back(wr_len); wr_len = 0; end
            prev_cs = cs_b;
            prev_wr = wr_b;
        end
        n_cmp++;
        if (cs_lens.size() != 13 || wr_lens.size() != 13 || last_rise != 78) begin
            n_fail++;
            $display("FAIL fast_counts: cs %0d wr %0d last rise %0d want 13/13/78",
                     cs_lens.size(), wr_lens.size(), last_rise);
        end
        foreach (cs_lens[k]) begin
            n_cmp++;
            if (cs_lens[k] != 5 || wr_lens[k] != 3 || idxs[k] != k) begin
                n_fail++;
                $display("FAIL fast_xfer %0d: cs %0d wr %0d sel %0d want 5/3/%0d", k, cs_lens[k], wr_lens[k], idxs[k], k);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            do_a    = ($urandom_range(0, 3) == 0);
            do_b    = ($urandom_range(0, 3) == 0);
            reset_a = ($urandom_range(0, 249) != 0);
            reset_b = ($urandom_range(0, 99) != 0);
            cyc();
            n_cmp++;
            if (out_a !== exp_a || !$onehot0(sel_a)) begin
                n_fail++; $display("FAIL random_a cyc %0d: got %h want %h", i, out_a, exp_a);
            end
            n_cmp++;
            if (out_b !== exp_b || !$onehot0(sel_b)) begin
                n_fail++; $display("FAIL random_b cyc %0d: got %h want %h", i, out_b, exp_b);
            end
        end
        reset_a = 1'b1; reset_b = 1'b1; do_a = 1'b0; do_b = 1'b0;
    endtask

    initial begin
        reset_a = 1'b0; reset_b = 1'b0; do_a = 1'b0; do_b = 1'b0;
        test_reset();
        reset_b = 1'b1;
        test_single_burst();
        test_back_to_back();
        test_reset_mid();
        test_fast_params();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
